// File: rtl/gwa_pkg.sv
// Shared types and constants for the parameterised vending controller.
package gwa_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_VEND    = 2'd1,
        ST_CHANGE  = 2'd2
    } state_t;

    localparam int COIN1 = 1;
    localparam int COIN2 = 2;

endpackage

// File: rtl/gwa_change_unit.sv
// Change payout engine: while started, pays out the largest coin that fits
// the presented credit each cycle and reports the credit left behind.
module gwa_change_unit
    import gwa_pkg::*;
#(
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] next_credit,
    output logic                eu1o,
    output logic                eu2o,
    output logic                done
);

    localparam logic [CREDIT_W-1:0] ONE = CREDIT_W'(COIN1);
    localparam logic [CREDIT_W-1:0] TWO = CREDIT_W'(COIN2);

    logic pay1;
    logic pay2;

    // Choose this cycle's coin (2 Euro preferred) and the credit remaining after it.
    always_comb begin
        pay1        = 1'b0;
        pay2        = 1'b0;
        next_credit = credit;
        if (start) begin
            if (credit >= TWO) begin
                pay2        = 1'b1;
                next_credit = credit - TWO;
            end else if (credit == ONE) begin
                pay1        = 1'b1;
                next_credit = credit - ONE;
            end
        end
        done = start && (next_credit == '0);
    end

    // Register the coin pulses so they appear in the cycle after the payout decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eu1o <= 1'b0;
            eu2o <= 1'b0;
        end else begin
            eu1o <= pay1;
            eu2o <= pay2;
        end
    end

endmodule

// File: rtl/gwa_vend_param.sv
// Two-product vending controller with coin acceptance, rejection, vend and
// change payout; prices and credit ceiling are parameters.
module gwa_vend_param
    import gwa_pkg::*;
#(
    parameter int PRICE_A    = 3,
    parameter int PRICE_B    = 4,
    parameter int MAX_CREDIT = 7,
    parameter int CREDIT_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                eu1,
    input  logic                eu2,
    input  logic                buy_a,
    input  logic                buy_b,
    input  logic                cancel,
    output logic                vend_a,
    output logic                vend_b,
    output logic                eu1o,
    output logic                eu2o,
    output logic                rej1o,
    output logic                rej2o,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    if (MAX_CREDIT < 2) begin : g_bad_max
        $error("MAX_CREDIT must be at least 2");
    end
    if (PRICE_A < 1 || PRICE_A > MAX_CREDIT) begin : g_bad_price_a
        $error("PRICE_A must lie in 1..MAX_CREDIT");
    end
    if (PRICE_B < 1 || PRICE_B > MAX_CREDIT) begin : g_bad_price_b
        $error("PRICE_B must lie in 1..MAX_CREDIT");
    end
    if (CREDIT_W < 2 || CREDIT_W > 30 || (MAX_CREDIT + 2) >= (1 << CREDIT_W)) begin : g_bad_width
        $error("CREDIT_W too narrow to hold MAX_CREDIT+2");
    end

    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] VAL1  = CREDIT_W'(COIN1);
    localparam logic [CREDIT_W-1:0] VAL2  = CREDIT_W'(COIN2);
    localparam logic [CREDIT_W-1:0] PRC_A = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] PRC_B = CREDIT_W'(PRICE_B);

    state_t              state_q;
    state_t              state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic                vend_a_n;
    logic                vend_b_n;
    logic                rej1_n;
    logic                rej2_n;
    logic                busy_n;

    logic                chg_start;
    logic [CREDIT_W-1:0] chg_credit;
    logic                chg_done;

    assign chg_start = (state_q == ST_CHANGE);

    gwa_change_unit #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (chg_start),
        .credit      (credit),
        .next_credit (chg_credit),
        .eu1o        (eu1o),
        .eu2o        (eu2o),
        .done        (chg_done)
    );

    // Next state, next credit and next-cycle pulses from the single highest-priority event.
    always_comb begin
        state_n  = state_q;
        credit_n = credit;
        vend_a_n = 1'b0;
        vend_b_n = 1'b0;
        rej1_n   = 1'b0;
        rej2_n   = 1'b0;
        unique case (state_q)
            ST_COLLECT: begin
                if (eu1) begin
                    if (credit + VAL1 <= MAX_C) credit_n = credit + VAL1;
                    else                        rej1_n   = 1'b1;
                    rej2_n = eu2;
                end else if (eu2) begin
                    if (credit + VAL2 <= MAX_C) credit_n = credit + VAL2;
                    else                        rej2_n   = 1'b1;
                end else if (cancel) begin
                    if (credit != '0) state_n = ST_CHANGE;
                end else if (buy_a) begin
                    if (credit >= PRC_A) begin
                        state_n  = ST_VEND;
                        credit_n = credit - PRC_A;
                        vend_a_n = 1'b1;
                    end
                end else if (buy_b) begin
                    if (credit >= PRC_B) begin
                        state_n  = ST_VEND;
                        credit_n = credit - PRC_B;
                        vend_b_n = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                rej1_n  = eu1;
                rej2_n  = eu2;
                state_n = (credit != '0) ? ST_CHANGE : ST_COLLECT;
            end
            ST_CHANGE: begin
                rej1_n   = eu1;
                rej2_n   = eu2;
                credit_n = chg_credit;
                if (chg_done) state_n = ST_COLLECT;
            end
            default: begin
                state_n  = ST_COLLECT;
                credit_n = '0;
            end
        endcase
        busy_n = (state_n != ST_COLLECT);
    end

    // State, credit and all controller outputs are held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            credit  <= '0;
            vend_a  <= 1'b0;
            vend_b  <= 1'b0;
            rej1o   <= 1'b0;
            rej2o   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_n;
            credit  <= credit_n;
            vend_a  <= vend_a_n;
            vend_b  <= vend_b_n;
            rej1o   <= rej1_n;
            rej2o   <= rej2_n;
            busy    <= busy_n;
        end
    end

endmodule

// File: tb/tb_gwa_vend_param.sv
// Bench for gwa_vend_param: hand-computed vector table, reset-in-payout
// sequence, and random traffic checked against a coin-queue model.
module tb_gwa_vend_param;

    localparam int PA  = 3;
    localparam int PB  = 4;
    localparam int MAX = 7;

    logic       clk;
    logic       rst_n;
    logic       eu1, eu2, buy_a, buy_b, cancel;
    logic       vend_a, vend_b, eu1o, eu2o, rej1o, rej2o, busy;
    logic [3:0] credit;

    // Input order {eu1, eu2, cancel, buy_a, buy_b}
    // Flag order {vend_a, vend_b, eu1o, eu2o, rej1o, rej2o, busy}
    typedef struct {
        logic [4:0] stim;
        logic [6:0] flags;
        int         cred;
    } vec_t;

    vec_t vecs[$];
    int   vectors;
    int   miscompares;

    int   mCredit;
    int   mVend;
    int   payQ[$];

    gwa_vend_param #(
        .PRICE_A    (PA),
        .PRICE_B    (PB),
        .MAX_CREDIT (MAX),
        .CREDIT_W   (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .eu1    (eu1),
        .eu2    (eu2),
        .buy_a  (buy_a),
        .buy_b  (buy_b),
        .cancel (cancel),
        .vend_a (vend_a),
        .vend_b (vend_b),
        .eu1o   (eu1o),
        .eu2o   (eu2o),
        .rej1o  (rej1o),
        .rej2o  (rej2o),
        .busy   (busy),
        .credit (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [4:0] s);
        {eu1, eu2, cancel, buy_a, buy_b} = s;
        @(posedge clk);
        #1;
        {eu1, eu2, cancel, buy_a, buy_b} = 5'b0;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] f, input int c, input bit waitEdge);
        logic [10:0] act;
        logic [10:0] req;
        if (waitEdge) @(negedge clk);
        act = {vend_a, vend_b, eu1o, eu2o, rej1o, rej2o, busy, credit};
        req = {f, 4'(c)};
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got flags=%b credit=%0d, want flags=%b credit=%0d",
                     name, act[10:4], act[3:0], req[10:4], req[3:0]);
        end
    endtask

    function automatic void modelReset();
        mCredit = 0;
        mVend   = 0;
        payQ.delete();
    endfunction

    function automatic void modelRefund();
        for (int i = 0; i < mCredit / 2; i++) payQ.push_back(2);
        if (mCredit % 2 == 1) payQ.push_back(1);
    endfunction

    // Advance the model by one clock edge with inputs s; returns next-cycle flags.
    function automatic logic [6:0] modelStep(input logic [4:0] s);
        logic va, vb, e1, e2, r1, r2;
        logic i1, i2, ic, ia, ib;
        int   c;
        {i1, i2, ic, ia, ib} = s;
        {va, vb, e1, e2, r1, r2} = 6'b0;
        if (mVend != 0) begin
            r1 = i1;
            r2 = i2;
            mVend = 0;
            modelRefund();
        end else if (payQ.size() > 0) begin
            r1 = i1;
            r2 = i2;
            c = payQ.pop_front();
            mCredit -= c;
            if (c == 2) e2 = 1'b1;
            else        e1 = 1'b1;
        end else if (i1) begin
            if (mCredit + 1 <= MAX) mCredit += 1;
            else                    r1 = 1'b1;
            r2 = i2;
        end else if (i2) begin
            if (mCredit + 2 <= MAX) mCredit += 2;
            else                    r2 = 1'b1;
        end else if (ic) begin
            modelRefund();
        end else if (ia) begin
            if (mCredit >= PA) begin
                mCredit -= PA;
                mVend = 1;
                va = 1'b1;
            end
        end else if (ib) begin
            if (mCredit >= PB) begin
                mCredit -= PB;
                mVend = 2;
                vb = 1'b1;
            end
        end
        return {va, vb, e1, e2, r1, r2, (mVend != 0) || (payQ.size() > 0)};
    endfunction

    task automatic modelCycle(input string name, input logic [4:0] s);
        logic [6:0] f;
        f = modelStep(s);
        applyStimulus(s);
        checkOutput(name, f, mCredit, 1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        {eu1, eu2, cancel, buy_a, buy_b} = 5'b0;

        vecs.push_back('{5'b01000, 7'b0000000, 2});
        vecs.push_back('{5'b01000, 7'b0000000, 4});
        vecs.push_back('{5'b00010, 7'b1000001, 1});
        vecs.push_back('{5'b01000, 7'b0000011, 1});
        vecs.push_back('{5'b00000, 7'b0010000, 0});
        vecs.push_back('{5'b00000, 7'b0000000, 0});
        vecs.push_back('{5'b01000, 7'b0000000, 2});
        vecs.push_back('{5'b01000, 7'b0000000, 4});
        vecs.push_back('{5'b01000, 7'b0000000, 6});
        vecs.push_back('{5'b01000, 7'b0000010, 6});
        vecs.push_back('{5'b10000, 7'b0000000, 7});
        vecs.push_back('{5'b10000, 7'b0000100, 7});
        vecs.push_back('{5'b00100, 7'b0000001, 7});
        vecs.push_back('{5'b00000, 7'b0001001, 5});
        vecs.push_back('{5'b00000, 7'b0001001, 3});
        vecs.push_back('{5'b00000, 7'b0001001, 1});
        vecs.push_back('{5'b00000, 7'b0010000, 0});
        vecs.push_back('{5'b10000, 7'b0000000, 1});
        vecs.push_back('{5'b00001, 7'b0000000, 1});
        vecs.push_back('{5'b10010, 7'b0000000, 2});
        vecs.push_back('{5'b01000, 7'b0000000, 4});
        vecs.push_back('{5'b00100, 7'b0000001, 4});
        vecs.push_back('{5'b11000, 7'b0001111, 2});
        vecs.push_back('{5'b00000, 7'b0001000, 0});
        vecs.push_back('{5'b11000, 7'b0000010, 1});
        vecs.push_back('{5'b01000, 7'b0000000, 3});
        vecs.push_back('{5'b10000, 7'b0000000, 4});
        vecs.push_back('{5'b00001, 7'b0100001, 0});
        vecs.push_back('{5'b00000, 7'b0000000, 0});
        vecs.push_back('{5'b00100, 7'b0000000, 0});
        vecs.push_back('{5'b00010, 7'b0000000, 0});
        vecs.push_back('{5'b01000, 7'b0000000, 2});
        vecs.push_back('{5'b10000, 7'b0000000, 3});
        vecs.push_back('{5'b00011, 7'b1000001, 0});
        vecs.push_back('{5'b00000, 7'b0000000, 0});
        vecs.push_back('{5'b01100, 7'b0000000, 2});
        vecs.push_back('{5'b00000, 7'b0000000, 2});

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 7'b0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stim);
            checkOutput($sformatf("table[%0d]", i), vecs[i].flags, vecs[i].cred, 1'b1);
        end

        // Reset asserted during the second payout cycle of a 7-Euro refund.
        rst_n = 1'b0;
        #2;
        checkOutput("reset_async_idle", 7'b0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        modelCycle("load_eu2_a", 5'b01000);
        modelCycle("load_eu2_b", 5'b01000);
        modelCycle("load_eu2_c", 5'b01000);
        modelCycle("load_eu1", 5'b10000);
        modelCycle("refund_start", 5'b00100);
        modelCycle("refund_first", 5'b00000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_change", 7'b0, 0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_held", 7'b0, 0, 1'b0);
        rst_n = 1'b1;
        modelReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'b0);
            checkOutput("after_reset_quiet", 7'b0, 0, 1'b1);
        end

        // Random traffic against the coin-queue model.
        for (int i = 0; i < 600; i++) begin
            logic [4:0] s;
            s[4] = ($urandom_range(0, 99) < 25);
            s[3] = ($urandom_range(0, 99) < 25);
            s[2] = ($urandom_range(0, 99) < 8);
            s[1] = ($urandom_range(0, 99) < 25);
            s[0] = ($urandom_range(0, 99) < 25);
            modelCycle($sformatf("random[%0d]", i), s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
